cpu_seq_ctrl: RTL and testbench

- Control unit that sequences the simple CPU datapath: register file, bus mux, A/G latches and ALU.
- Owns the state register and instruction register.
- Fetches instructions over a valid/ack handshake, decodes the 3-bit opcode, and drives Moore-style per-state strobes.
- Sits between instruction memory and the datapath; the datapath holds no control state of its own.

---
 rtl/cpu_pkg.sv | 57 +++++
 rtl/cpu_seq_ctrl_next_state.sv | 45 ++++
 rtl/cpu_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU sequencer control unit:
//   - 5-bit state encodings (state_e)
//   - opcode constants OPC_LOAD..OPC_AND
//   - ALU_OP_* constants driven on alu_op
//   - instruction field widths and slice positions
//   - alu_op_of(): maps an ALU opcode to its alu_op selector
// Related optional feature macro (used by cpu_seq_ctrl): CPU_SEQ_CTRL_PERF_CNT_EN
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int CPU_STATE_W = 5;
    localparam int CPU_IDX_W   = 3;
    localparam int CPU_OPC_W   = 3;

    // Instruction layout: {code, rx, ry}
    localparam int CPU_CODE_LSB = 2 * CPU_IDX_W;
    localparam int CPU_RX_LSB   = CPU_IDX_W;
    localparam int CPU_RY_LSB   = 0;

    typedef enum logic [CPU_STATE_W-1:0] {
        ST_IDLE   = 5'b11111,
        ST_FETCH  = 5'b10000,
        ST_DECODE = 5'b00000,
        ST_LOAD   = 5'b00001,
        ST_MOV    = 5'b00010,
        ST_ALU1   = 5'b00011,
        ST_ALU2   = 5'b00100,
        ST_ALU3   = 5'b00101
    } state_e;

    localparam logic [CPU_OPC_W-1:0] OPC_LOAD = 3'b000;
    localparam logic [CPU_OPC_W-1:0] OPC_MOV  = 3'b001;
    localparam logic [CPU_OPC_W-1:0] OPC_ADD  = 3'b010;
    localparam logic [CPU_OPC_W-1:0] OPC_XOR  = 3'b011;
    localparam logic [CPU_OPC_W-1:0] OPC_OR   = 3'b100;
    localparam logic [CPU_OPC_W-1:0] OPC_AND  = 3'b101;

    localparam logic [1:0] ALU_OP_ADD = 2'b00;
    localparam logic [1:0] ALU_OP_XOR = 2'b01;
    localparam logic [1:0] ALU_OP_OR  = 2'b10;
    localparam logic [1:0] ALU_OP_AND = 2'b11;

    // Equivalent to (code - 3'b010) truncated to two bits for the ALU opcodes.
    function automatic logic [1:0] alu_op_of(input logic [CPU_OPC_W-1:0] code);
        logic [1:0] op;
        case (code)
            OPC_XOR: op = ALU_OP_XOR;
            OPC_OR:  op = ALU_OP_OR;
            OPC_AND: op = ALU_OP_AND;
            default: op = ALU_OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/cpu_seq_ctrl_next_state.sv
// ----------------------------------------------------------------------------
// ctrl_next_state
// Pure combinational next-state logic of the CPU sequencer.
// Ports:
//   i_state        current state register value
//   i_code         opcode field of the instruction register
//   i_start        leave IDLE request
//   i_instr_valid  instruction word on the memory interface is valid
//   o_next         state to load on the next clock edge
// ----------------------------------------------------------------------------
module ctrl_next_state
    import cpu_pkg::*;
(
    input  state_e               i_state,
    input  logic [CPU_OPC_W-1:0] i_code,
    input  logic                 i_start,
    input  logic                 i_instr_valid,
    output state_e               o_next
);

    always_comb begin
        o_next = ST_IDLE;
        case (i_state)
            ST_IDLE:   o_next = i_start ? ST_FETCH : ST_IDLE;
            ST_FETCH:  o_next = i_instr_valid ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (i_code)
                    OPC_LOAD:                         o_next = ST_LOAD;
                    OPC_MOV:                          o_next = ST_MOV;
                    OPC_ADD, OPC_XOR, OPC_OR, OPC_AND: o_next = ST_ALU1;
                    // undefined opcodes are dropped and the next word fetched
                    default:                          o_next = ST_FETCH;
                endcase
            end
            ST_LOAD:   o_next = ST_FETCH;
            ST_MOV:    o_next = ST_FETCH;
            ST_ALU1:   o_next = ST_ALU2;
            ST_ALU2:   o_next = ST_ALU3;
            ST_ALU3:   o_next = ST_FETCH;
            // any unencoded value recovers through IDLE
            default:   o_next = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// ----------------------------------------------------------------------------
// cpu_seq_ctrl
// Control unit sequencing the simple CPU datapath (register file, bus mux,
// A/G latches, ALU). Holds the state register and instruction register,
// fetches over a valid/ack handshake and drives Moore-style strobes decoded
// from the current state and IR.
// Optional feature macro: CPU_SEQ_CTRL_PERF_CNT_EN adds retired_cnt.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   start        leave IDLE (sampled only in IDLE)
//   instr        instruction word {code, rx, ry}
//   instr_valid  instr is valid this cycle
//   instr_ack    instr captured into IR this cycle
//   reg_en       one-hot register write enable
//   bus_sel      register index driven onto the bus
//   din_out      external din drives the bus
//   a_in/g_in    load A latch from bus / G latch from ALU
//   g_out        G drives the bus
//   alu_op       00 add, 01 xor, 10 or, 11 and
//   done         instruction completes this cycle
//   illegal      undefined opcode decoded this cycle
//   busy         state is not IDLE
//   state_q      current state (debug)
//   retired_cnt  [macro only] count of completed instructions, wraps
// ----------------------------------------------------------------------------
module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int IDX_W   = CPU_IDX_W,
    parameter int REG_CNT = 2**IDX_W,
    parameter int OPC_W   = CPU_OPC_W,
    parameter int INSTR_W = OPC_W + 2*IDX_W
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [INSTR_W-1:0]     instr,
    input  logic                   instr_valid,
    output logic                   instr_ack,
    output logic [REG_CNT-1:0]     reg_en,
    output logic [IDX_W-1:0]       bus_sel,
    output logic                   din_out,
    output logic                   a_in,
    output logic                   g_in,
    output logic                   g_out,
    output logic [1:0]             alu_op,
    output logic                   done,
    output logic                   illegal,
    output logic                   busy,
    output logic [CPU_STATE_W-1:0] state_q
`ifdef CPU_SEQ_CTRL_PERF_CNT_EN
    ,
    output logic [15:0]            retired_cnt
`endif
);

    state_e             r_state;
    state_e             w_next;
    logic [INSTR_W-1:0] r_ir;
    logic [OPC_W-1:0]   w_code;
    logic [IDX_W-1:0]   w_rx;
    logic [IDX_W-1:0]   w_ry;
    logic [REG_CNT-1:0] w_rx_dec;

    assign w_code   = r_ir[CPU_CODE_LSB +: OPC_W];
    assign w_rx     = r_ir[CPU_RX_LSB +: IDX_W];
    assign w_ry     = r_ir[CPU_RY_LSB +: IDX_W];
    assign w_rx_dec = REG_CNT'(1) << w_rx;

    ctrl_next_state u_next (
        .i_state       (r_state),
        .i_code        (w_code),
        .i_start       (start),
        .i_instr_valid (instr_valid),
        .o_next        (w_next)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_FETCH && instr_valid) begin
                r_ir <= instr;
            end
        end
    end

    always_comb begin
        instr_ack = 1'b0;
        reg_en    = '0;
        bus_sel   = '0;
        din_out   = 1'b0;
        a_in      = 1'b0;
        g_in      = 1'b0;
        g_out     = 1'b0;
        alu_op    = ALU_OP_ADD;
        done      = 1'b0;
        illegal   = 1'b0;
        case (r_state)
            ST_FETCH:  instr_ack = instr_valid;
            ST_DECODE: illegal   = (w_code > OPC_AND);
            ST_LOAD: begin
                din_out = 1'b1;
                reg_en  = w_rx_dec;
                done    = 1'b1;
            end
            ST_MOV: begin
                bus_sel = w_ry;
                reg_en  = w_rx_dec;
                done    = 1'b1;
            end
            ST_ALU1: begin
                bus_sel = w_rx;
                a_in    = 1'b1;
            end
            ST_ALU2: begin
                bus_sel = w_ry;
                g_in    = 1'b1;
                alu_op  = alu_op_of(w_code);
            end
            ST_ALU3: begin
                g_out  = 1'b1;
                reg_en = w_rx_dec;
                done   = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy    = (r_state != ST_IDLE);
    assign state_q = r_state;

`ifdef CPU_SEQ_CTRL_PERF_CNT_EN
    logic [15:0] r_retired;

    // done is only ever high in LOAD/MOV/ALU3, so illegal ops never count
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_retired <= '0;
        end else if (done) begin
            r_retired <= r_retired + 16'd1;
        end
    end

    assign retired_cnt = r_retired;
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
module tb_cpu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [8:0] instr = '0;
    logic       instr_valid = 1'b0;
    logic       instr_ack;
    logic [7:0] reg_en;
    logic [2:0] bus_sel;
    logic       din_out, a_in, g_in, g_out;
    logic [1:0] alu_op;
    logic       done, illegal, busy;
    logic [4:0] state_q;
`ifdef CPU_SEQ_CTRL_PERF_CNT_EN
    logic [15:0] retired_cnt;
`endif

    cpu_seq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ack   (instr_ack),
        .reg_en      (reg_en),
        .bus_sel     (bus_sel),
        .din_out     (din_out),
        .a_in        (a_in),
        .g_in        (g_in),
        .g_out       (g_out),
        .alu_op      (alu_op),
        .done        (done),
        .illegal     (illegal),
        .busy        (busy),
        .state_q     (state_q)
`ifdef CPU_SEQ_CTRL_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: an instruction, once acknowledged, expands into a
    // queue of per-cycle output pictures. No queue -> FETCH or IDLE.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [4:0] st;
        logic [7:0] re;
        logic [2:0] bs;
        logic       din, ai, gi, go;
        logic [1:0] op;
        logic       dn, il, ak, by;
    } rec_t;

    rec_t        m_q[$];
    bit          m_run = 1'b0;
    logic [15:0] m_ret = '0;

    function automatic rec_t blank(input logic [4:0] st);
        rec_t r = '0;
        r.st = st;
        r.by = (st != 5'b11111);
        return r;
    endfunction

    function automatic rec_t expect_now();
        rec_t r;
        if (!m_run)              r = blank(5'b11111);
        else if (m_q.size() != 0) r = m_q[0];
        else begin
            r = blank(5'b10000);
            r.ak = instr_valid;
        end
        return r;
    endfunction

    task automatic schedule(input logic [8:0] ins);
        int   code = int'(ins[8:6]);
        int   rx   = int'(ins[5:3]);
        int   ry   = int'(ins[2:0]);
        rec_t r;
        r = blank(5'b00000); r.il = (code >= 6); m_q.push_back(r);
        if (code == 0) begin
            r = blank(5'b00001); r.din = 1'b1; r.re = 8'(1 << rx); r.dn = 1'b1; m_q.push_back(r);
        end else if (code == 1) begin
            r = blank(5'b00010); r.bs = 3'(ry); r.re = 8'(1 << rx); r.dn = 1'b1; m_q.push_back(r);
        end else if (code <= 5) begin
            r = blank(5'b00011); r.bs = 3'(rx); r.ai = 1'b1; m_q.push_back(r);
            r = blank(5'b00100); r.bs = 3'(ry); r.gi = 1'b1; r.op = 2'(code - 2); m_q.push_back(r);
            r = blank(5'b00101); r.go = 1'b1; r.re = 8'(1 << rx); r.dn = 1'b1; m_q.push_back(r);
        end
    endtask

    // One clock cycle: apply inputs after the edge, compare mid-cycle,
    // then let the model take the coming edge.
    task automatic drive(input bit r, input bit s, input logic [8:0] ins, input bit v);
        rec_t e;
        @(posedge clk);
        #1;
        rst = r; start = s; instr = ins; instr_valid = v;
        @(negedge clk);
        e = expect_now();
        chk("cycle", {6'b0, state_q, reg_en, bus_sel, din_out, a_in, g_in, g_out,
                      alu_op, done, illegal, instr_ack, busy}, {6'b0, e});
`ifdef CPU_SEQ_CTRL_PERF_CNT_EN
        chk("retired_cnt", {16'b0, retired_cnt}, {16'b0, m_ret});
`endif
        if (!rst) begin
            m_run = 1'b0;
            m_q.delete();
            m_ret = '0;
        end else begin
            if (e.dn) m_ret = m_ret + 16'd1;
            if (!m_run) begin
                if (start) m_run = 1'b1;
            end else if (m_q.size() != 0) begin
                void'(m_q.pop_front());
            end else if (instr_valid) begin
                schedule(instr);
            end
        end
    endtask

    logic [8:0] prog [4] = '{9'b000_001_000, 9'b001_010_001, 9'b110_000_000, 9'b000_111_000};

    initial begin
        // reset
        drive(0, 0, 9'h0, 0);
        drive(0, 0, 9'h0, 0);
        chk("rst_state", 32'(state_q), 32'h1F);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_strobes", 32'({reg_en, din_out, a_in, g_in, g_out, done, illegal, instr_ack}), 32'h0);
        for (int i = 0; i < 5; i++) drive(1, 0, 9'h0, 0);
        chk("idle_hold", 32'(state_q), 32'h1F);
        drive(1, 1, 9'h0, 0);

        // LOAD r3
        drive(1, 0, 9'b000_011_000, 1);
        chk("load_fetch", 32'(state_q), 32'h10);
        chk("load_ack", 32'(instr_ack), 32'h1);
        drive(1, 0, 9'h0, 0);
        chk("load_decode", 32'(state_q), 32'h00);
        drive(1, 0, 9'h0, 0);
        chk("load_exec", 32'({din_out, reg_en, done}), 32'({1'b1, 8'b0000_1000, 1'b1}));

        // XOR r2, r5
        drive(1, 0, 9'b011_010_101, 1);
        chk("xor_ack", 32'(instr_ack), 32'h1);
        drive(1, 0, 9'h0, 0);
        drive(1, 0, 9'h0, 0);
        chk("xor_alu1", 32'({bus_sel, a_in}), 32'({3'd2, 1'b1}));
        drive(1, 0, 9'h0, 0);
        chk("xor_alu2", 32'({bus_sel, alu_op, g_in}), 32'({3'd5, 2'b01, 1'b1}));
        drive(1, 0, 9'h0, 0);
        chk("xor_alu3", 32'({g_out, reg_en, done}), 32'({1'b1, 8'b0000_0100, 1'b1}));

        // fetch stall, then illegal opcode
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 9'($urandom), 0);
            chk("stall", 32'({state_q, instr_ack}), 32'({5'b10000, 1'b0}));
        end
        drive(1, 0, 9'b111_001_001, 1);
        chk("stall_ack", 32'(instr_ack), 32'h1);
        drive(1, 0, 9'h0, 0);
        chk("illegal_dec", 32'({state_q, illegal, reg_en, done}), 32'({5'b00000, 1'b1, 8'h00, 1'b0}));

        // reset during ALU2
        drive(1, 0, 9'b010_001_010, 1);
        chk("ill_to_fetch", 32'({state_q, instr_ack}), 32'({5'b10000, 1'b1}));
        drive(1, 0, 9'h0, 0);
        drive(1, 0, 9'h0, 0);
        drive(0, 0, 9'h0, 0);
        chk("abort_alu2", 32'({state_q, g_in}), 32'({5'b00100, 1'b1}));
        drive(1, 0, 9'h0, 0);
        chk("abort_idle", 32'({state_q, reg_en, done}), 32'({5'b11111, 8'h00, 1'b0}));

        // three legal plus one illegal instruction
        drive(1, 1, 9'h0, 0);
        for (int k = 0; k < 4; k++) begin
            bit found = 1'b0;
            drive(1, 0, prog[k], 1);
            for (int w = 0; w < 8 && !found; w++) begin
                drive(1, 0, 9'h0, 0);
                if (state_q == 5'b10000) found = 1'b1;
            end
            chk("prog_return", 32'(found), 32'h1);
        end
`ifdef CPU_SEQ_CTRL_PERF_CNT_EN
        chk("retired_3", 32'(retired_cnt), 32'd3);
`endif

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
                  9'($urandom), ($urandom_range(0, 1) == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
